// File: rtl/axis_sync_packet_fifo.sv
// Single-clock AXI4-Stream FIFO carrying {tlast, tkeep, tdata}, with occupancy
// reporting and an optional store-and-forward mode that holds frames until complete.
module axis_sync_packet_fifo #(
    parameter int DATA_WIDTH         = 32,
    parameter int DEPTH              = 16,
    parameter int PACKET_MODE        = 0,
    parameter int ALMOST_FULL_THRESH = DEPTH - 2
) (
    input  logic                        axis_clk,
    input  logic                        axis_rst,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic                        s_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic [$clog2(DEPTH):0]      fill_level,
    output logic [$clog2(DEPTH):0]      pkt_count,
    output logic                        almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int KW = DATA_WIDTH / 8;
    localparam int EW = DATA_WIDTH + KW + 1;
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
    localparam logic [AW:0] AF_THRESH = (AW + 1)'(ALMOST_FULL_THRESH);

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   fill_q;
    logic [AW:0]   pkt_q;
    logic          cut_through;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;
    logic          pkt_inc;
    logic          pkt_dec;

    // Handshake: a beat moves on an edge where valid && ready are both high.
    // tready depends only on registered state, so full blocks a same-cycle
    // write even when a read frees an entry on that edge.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign s_axis_tready = !full;
    assign wr_en         = s_axis_tvalid && !full;
    assign rd_en         = m_axis_tvalid && m_axis_tready;

    assign head          = mem[rd_ptr[AW-1:0]];
    assign m_axis_tlast  = head[EW-1];
    assign m_axis_tkeep  = head[DATA_WIDTH +: KW];
    assign m_axis_tdata  = head[DATA_WIDTH-1:0];

    // In packet mode the head is only offered once a whole frame is stored,
    // or when an oversize frame has filled the FIFO and must stream through.
    assign m_axis_tvalid = (PACKET_MODE != 0) ? (!empty && ((pkt_q != '0) || cut_through))
                                              : !empty;

    assign pkt_inc = wr_en && s_axis_tlast;
    assign pkt_dec = rd_en && m_axis_tlast;

    assign fill_level  = fill_q;
    assign pkt_count   = pkt_q;
    assign almost_full = (fill_q >= AF_THRESH);

    always_ff @(posedge axis_clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            fill_q <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   fill_q <= fill_q + PTR_ONE;
                2'b01:   fill_q <= fill_q - PTR_ONE;
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            pkt_q <= '0;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_q <= pkt_q + PTR_ONE;
                2'b01:   pkt_q <= pkt_q - PTR_ONE;
                default: pkt_q <= pkt_q;
            endcase
        end
    end

    // A full FIFO holding no frame end can never complete a frame; release it.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            cut_through <= 1'b0;
        end else if (pkt_dec) begin
            cut_through <= 1'b0;
        end else if (full && (pkt_q == '0)) begin
            cut_through <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_sync_packet_fifo.sv
// Directed bench: one cut-through and one store-and-forward instance sharing
// clock and reset, each driven by its own stimulus.
module tb_axis_sync_packet_fifo;

    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          c_s_valid, c_s_ready, c_s_last, c_m_valid, c_m_ready, c_m_last, c_af;
    logic [DW-1:0] c_s_data, c_m_data;
    logic [KW-1:0] c_s_keep, c_m_keep;
    logic [AW:0]   c_fill, c_pkt;

    logic          p_s_valid, p_s_ready, p_s_last, p_m_valid, p_m_ready, p_m_last, p_af;
    logic [DW-1:0] p_s_data, p_m_data;
    logic [KW-1:0] p_s_keep, p_m_keep;
    logic [AW:0]   p_fill, p_pkt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW:0] exp_q[$];

    axis_sync_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(0)) dut_ct (
        .axis_clk(clk), .axis_rst(rst),
        .s_axis_tvalid(c_s_valid), .s_axis_tready(c_s_ready), .s_axis_tdata(c_s_data),
        .s_axis_tkeep(c_s_keep), .s_axis_tlast(c_s_last),
        .m_axis_tvalid(c_m_valid), .m_axis_tready(c_m_ready), .m_axis_tdata(c_m_data),
        .m_axis_tkeep(c_m_keep), .m_axis_tlast(c_m_last),
        .fill_level(c_fill), .pkt_count(c_pkt), .almost_full(c_af)
    );

    axis_sync_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1)) dut_sf (
        .axis_clk(clk), .axis_rst(rst),
        .s_axis_tvalid(p_s_valid), .s_axis_tready(p_s_ready), .s_axis_tdata(p_s_data),
        .s_axis_tkeep(p_s_keep), .s_axis_tlast(p_s_last),
        .m_axis_tvalid(p_m_valid), .m_axis_tready(p_m_ready), .m_axis_tdata(p_m_data),
        .m_axis_tkeep(p_m_keep), .m_axis_tlast(p_m_last),
        .fill_level(p_fill), .pkt_count(p_pkt), .almost_full(p_af)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rx;
        int tx;
        int cnt;
        logic rd;
        logic wr;
        logic [DW:0] beat;

        c_s_valid = 0; c_s_data = '0; c_s_keep = '0; c_s_last = 0; c_m_ready = 0;
        p_s_valid = 0; p_s_data = '0; p_s_keep = '0; p_s_last = 0; p_m_ready = 0;

        // ---- reset state
        repeat (3) tick();
        check("rst_fill", c_fill, 0);
        check("rst_pkt", c_pkt, 0);
        check("rst_mvalid", c_m_valid, 0);
        check("rst_sready", c_s_ready, 1);
        check("rst_af", c_af, 0);
        check("rst_sf_mvalid", p_m_valid, 0);
        check("rst_sf_sready", p_s_ready, 1);
        rst = 1'b0;

        // ---- cut-through: 5 beats stored then drained in order
        for (int i = 1; i <= 5; i++) begin
            c_s_valid = 1; c_s_data = DW'(i); c_s_keep = KW'(i); c_s_last = (i == 5);
            tick();
        end
        c_s_valid = 0; c_s_last = 0;
        check("ct_fill5", c_fill, 5);
        check("ct_pkt1", c_pkt, 1);
        c_m_ready = 1;
        for (int i = 1; i <= 5; i++) begin
            check("ct_valid", c_m_valid, 1);
            check("ct_data", c_m_data, 64'(i));
            check("ct_keep", c_m_keep, 64'(i));
            check("ct_last", c_m_last, (i == 5));
            tick();
        end
        check("ct_drained_valid", c_m_valid, 0);
        check("ct_drained_fill", c_fill, 0);
        check("ct_drained_pkt", c_pkt, 0);
        c_m_ready = 0;

        // ---- full / backpressure / almost_full
        for (int i = 1; i <= 16; i++) begin
            c_s_valid = 1; c_s_data = 32'h100 + DW'(i - 1); c_s_keep = '1;
            tick();
            check("full_fill", c_fill, 64'(i));
            check("full_af", c_af, (i >= 14));
            check("full_sready", c_s_ready, (i < 16));
        end
        c_s_data = 32'h110;
        tick();
        check("full_reject", c_fill, 16);
        c_m_ready = 1;
        check("full_head", c_m_data, 32'h100);
        tick();
        check("full_read_fill", c_fill, 15);
        check("full_read_sready", c_s_ready, 1);
        c_m_ready = 0;
        tick();
        check("full_17th_fill", c_fill, 16);
        c_s_valid = 0;
        c_m_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            check("wrap_data", c_m_data, 32'h100 + 64'(i));
            tick();
        end
        check("wrap_empty", c_fill, 0);
        c_m_ready = 0;

        // ---- simultaneous write/read at fill_level 8
        for (int i = 0; i < 8; i++) begin
            beat = {1'($urandom_range(0, 1)), DW'($urandom)};
            c_s_valid = 1; c_s_data = beat[DW-1:0]; c_s_last = beat[DW];
            exp_q.push_back(beat);
            tick();
        end
        c_m_ready = 1;
        for (int n = 0; n < 100; n++) begin
            check("sim_data", c_m_data, exp_q[0][DW-1:0]);
            check("sim_last", c_m_last, exp_q[0][DW]);
            beat = {1'($urandom_range(0, 1)), DW'($urandom)};
            c_s_data = beat[DW-1:0]; c_s_last = beat[DW];
            exp_q.push_back(beat);
            tick();
            void'(exp_q.pop_front());
            cnt = 0;
            foreach (exp_q[k]) cnt += int'(exp_q[k][DW]);
            check("sim_fill", c_fill, 8);
            check("sim_pkt", c_pkt, 64'(cnt));
        end
        c_s_valid = 0; c_s_last = 0;
        while (exp_q.size() > 0) begin
            check("sim_drain", c_m_data, exp_q[0][DW-1:0]);
            tick();
            void'(exp_q.pop_front());
        end
        check("sim_empty_fill", c_fill, 0);
        check("sim_empty_pkt", c_pkt, 0);
        c_m_ready = 0;

        // ---- store-and-forward: 4-beat frame held until tlast is written
        p_m_ready = 1; p_s_keep = '1;
        for (int i = 0; i < 4; i++) begin
            check("sf_hold", p_m_valid, 0);
            p_s_valid = 1; p_s_data = 32'h400 + DW'(i); p_s_last = (i == 3);
            tick();
        end
        p_s_valid = 0; p_s_last = 0;
        for (int i = 0; i < 4; i++) begin
            check("sf_valid", p_m_valid, 1);
            check("sf_data", p_m_data, 32'h400 + 64'(i));
            check("sf_pkt", p_pkt, 1);
            check("sf_last", p_m_last, (i == 3));
            tick();
        end
        check("sf_pkt_done", p_pkt, 0);
        check("sf_valid_done", p_m_valid, 0);
        p_m_ready = 0;

        // ---- oversize frame: 20 beats into a 16-entry store-and-forward FIFO
        for (int i = 0; i < 16; i++) begin
            check("ovs_sready", p_s_ready, 1);
            p_s_valid = 1; p_s_data = 32'h200 + DW'(i); p_s_last = 0;
            tick();
        end
        p_s_data = 32'h210;
        check("ovs_full", p_s_ready, 0);
        check("ovs_fill", p_fill, 16);
        check("ovs_pkt", p_pkt, 0);
        tick();
        check("ovs_cut_set", dut_sf.cut_through, 1);
        check("ovs_mvalid", p_m_valid, 1);
        p_m_ready = 1;
        rx = 0; tx = 16;
        for (int n = 0; n < 200 && rx < 20; n++) begin
            rd = p_m_valid && p_m_ready;
            wr = p_s_valid && p_s_ready;
            if (rd) begin
                check("ovs_data", p_m_data, 32'h200 + 64'(rx));
                check("ovs_last", p_m_last, (rx == 19));
                rx++;
            end
            tick();
            if (wr) begin
                tx++;
                if (tx < 20) begin
                    p_s_data = 32'h200 + DW'(tx); p_s_last = (tx == 19);
                end else begin
                    p_s_valid = 0; p_s_last = 0;
                end
            end
        end
        check("ovs_count", 64'(rx), 20);
        check("ovs_cut_clear", dut_sf.cut_through, 0);
        check("ovs_mvalid_done", p_m_valid, 0);
        check("ovs_fill_done", p_fill, 0);
        p_m_ready = 0;

        // ---- mid-packet reset
        for (int i = 0; i < 3; i++) begin
            p_s_valid = 1; p_s_data = 32'h500 + DW'(i); p_s_last = 0;
            c_s_valid = 1; c_s_data = 32'h600 + DW'(i); c_s_last = (i == 2);
            tick();
        end
        p_s_valid = 0; c_s_valid = 0; c_s_last = 0;
        check("mrst_pre_fill", p_fill, 3);
        check("mrst_pre_ct_valid", c_m_valid, 1);
        #3 rst = 1'b1;
        #1;
        check("mrst_fill", p_fill, 0);
        check("mrst_pkt", p_pkt, 0);
        check("mrst_sready", p_s_ready, 1);
        check("mrst_ct_fill", c_fill, 0);
        check("mrst_ct_pkt", c_pkt, 0);
        check("mrst_ct_valid", c_m_valid, 0);
        #2 rst = 1'b0;
        tick();
        p_m_ready = 1;
        p_s_valid = 1; p_s_data = 32'h300; p_s_last = 0;
        tick();
        check("mrst_hold", p_m_valid, 0);
        p_s_data = 32'h301; p_s_last = 1;
        tick();
        p_s_valid = 0; p_s_last = 0;
        check("mrst_valid", p_m_valid, 1);
        check("mrst_data0", p_m_data, 32'h300);
        tick();
        check("mrst_data1", p_m_data, 32'h301);
        check("mrst_last1", p_m_last, 1);
        tick();
        check("mrst_empty", p_m_valid, 0);
        check("mrst_fill_end", p_fill, 0);
        p_m_ready = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_sync_packet_fifo.md
# axis_sync_packet_fifo

Single-clock AXI4-Stream FIFO with TKEEP/TLAST sideband, full ready/valid backpressure, occupancy reporting and an optional store-and-forward packet mode. It is the same-clock companion of the team's dual-clock AXIS data FIFO and is used inside one clock domain, in front of packet consumers that must not see a stalled partial frame.

## Interface
Parameters:
- DATA_WIDTH, 32: tdata width in bits; multiple of 8.
- DEPTH, 16: entries; power of two, >= 4.
- PACKET_MODE, 0: 0 = cut-through; 1 = store-and-forward.
- ALMOST_FULL_THRESH, DEPTH-2: almost_full asserts when fill_level >= this value; range 1..DEPTH.

Ports (AW = $clog2(DEPTH)):
- axis_clk  in  1  sole clock; all logic on the rising edge.
- axis_rst  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  upstream beat valid.
- s_axis_tready  out  1  FIFO can accept a beat.
- s_axis_tdata  in  DATA_WIDTH  upstream data.
- s_axis_tkeep  in  DATA_WIDTH/8  byte qualifiers, stored unmodified.
- s_axis_tlast  in  1  end of packet.
- m_axis_tvalid  out  1  downstream beat valid.
- m_axis_tready  in  1  downstream accepts.
- m_axis_tdata  out  DATA_WIDTH  head-entry data.
- m_axis_tkeep  out  DATA_WIDTH/8  head-entry keep.
- m_axis_tlast  out  1  head-entry last.
- fill_level  out  AW+1  stored entries, 0..DEPTH.
- pkt_count  out  AW+1  stored entries with tlast=1.
- almost_full  out  1  fill_level >= ALMOST_FULL_THRESH.

## Operation
- Storage: DEPTH-entry register array of {tlast, tkeep, tdata}. Write and read pointers are AW+1 bits; the MSB is the wrap bit. full = (addresses equal, wrap bits differ); empty = (pointers equal).
- Write: occurs when s_axis_tvalid && s_axis_tready. s_axis_tready = !full. A read in the same cycle does not free space for that cycle's write, so there is no full-state pass-through.
- Read: occurs when m_axis_tvalid && m_axis_tready. m_axis_t{data,keep,last} present the entry at the read pointer and are combinational from the array. When m_axis_tvalid = 0, their values are don't-care.
- fill_level: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- pkt_count: +1 on a write with tlast=1, -1 on a read with tlast=1. Both together leave it unchanged.
- PACKET_MODE=0: m_axis_tvalid = !empty.
- PACKET_MODE=1: m_axis_tvalid = !empty && (pkt_count != 0 || cut_through).
  - cut_through is a register. It sets when full && pkt_count == 0, which is the oversize-packet deadlock escape.
  - It clears on a read of a tlast=1 beat.
  - While cut_through is set and the FIFO goes empty mid-packet, m_axis_tvalid drops and resumes when data arrives.
- AXIS rules: once m_axis_tvalid is asserted, it and the payload stay stable until the read handshake. The block never deasserts valid without a handshake, because entries are only removed by reads.
- No beat is ever dropped, duplicated or reordered. tkeep is not interpreted.

## Timing
- Reset (axis_rst high, asynchronous): pointers = 0, fill_level = 0, pkt_count = 0, cut_through = 0, m_axis_tvalid = 0, s_axis_tready = 1, almost_full = 0 (ALMOST_FULL_THRESH >= 1). A reset asserted mid-packet discards all contents immediately, including partial packets. Release is synchronous to axis_clk, and the first write is accepted on the first edge after release.
- Cut-through latency: a beat written at edge N appears on m_axis with m_axis_tvalid = 1 after edge N, so it can be read at edge N+1.
- Store-and-forward latency: no beat of a packet is presented until the edge that writes its tlast beat. The first beat is valid after that edge.
- fill_level, pkt_count, almost_full and s_axis_tready update on the same edge as the handshake that changes them. All four are registered or decoded from registers, with no combinational path from the *_tvalid or *_tready inputs.
- Throughput: one write and one read per cycle sustained when neither full nor empty.
- Wrap-around: pointers wrap modulo 2*DEPTH, and behaviour is identical across wraps.

## Test plan
- Cut-through, DEPTH=16: write 5 beats 0x1..0x5 with m_axis_tready=0 -> fill_level=5. Raise ready -> beats emerge 0x1..0x5 in order on consecutive cycles and fill_level returns to 0.
- Full/backpressure: write 16 beats with ready=0 -> s_axis_tready=0 after the 16th edge, almost_full=1 from fill_level 14, and a 17th tvalid beat is not accepted. One read -> s_axis_tready=1 on the next cycle, and a 17th write lands correctly after wrap.
- Store-and-forward: send a 4-beat packet with tlast on beat 4 and m_axis_tready=1 throughout -> m_axis_tvalid stays 0 until after the edge writing beat 4, then 4 beats are read back-to-back and pkt_count goes 1 -> 0 on the final read.
- Oversize packet, PACKET_MODE=1, DEPTH=16: send a 20-beat packet with ready=0 -> full with pkt_count=0 sets cut_through and m_axis_tvalid=1. Raise ready -> all 20 beats delivered in order, and cut_through clears after tlast is read.
- Simultaneous write/read at fill_level=8 for 100 cycles with random tlast -> fill_level stays 8 and pkt_count tracks the in-FIFO tlast count exactly.
- Mid-packet reset: 3 beats stored, assert axis_rst for 1 cycle between edges -> outputs reach reset values immediately, and the next packet is delivered with no residue.
